// File: rtl/sparse_b_pkg.sv
// Shared constants and FSM state type for the sparse_mult_by_B block scheduler.
package sparse_b_pkg;

    localparam int IN_PER_BLOCK  = 5;
    localparam int OUT_PER_IN    = 11;
    localparam int OUT_PER_BLOCK = IN_PER_BLOCK * OUT_PER_IN;
    localparam int IN_CNT_W      = $clog2(IN_PER_BLOCK + 1);
    localparam int OUT_CNT_W     = $clog2(OUT_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin pick: on a tie the channel that did not win last time gets the grant.
module rr_grant2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |valid;
        grant       = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/sparse_mult_by_b_sched.sv
// Time-shares one sparse_mult_by_B core between two requesters, one whole block
// (5 words in, 55 words out) at a time, routing results back to the block owner.
module sparse_mult_by_b_sched
    import sparse_b_pkg::*;
#(
    parameter int WIDTH        = 96,
    parameter int IN_PER_BLOCK = 5,
    parameter int OUT_PER_IN   = 11
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_s0_data,
    input  logic             i_s0_valid,
    output logic             o_s0_ready,
    input  logic [WIDTH-1:0] i_s1_data,
    input  logic             i_s1_valid,
    output logic             o_s1_ready,
    output logic [WIDTH-1:0] o_core_in_data,
    output logic             o_core_in_valid,
    input  logic             i_core_in_ready,
    input  logic [WIDTH-1:0] i_core_out_data,
    input  logic             i_core_out_valid,
    output logic             o_core_out_ready,
    output logic [WIDTH-1:0] o_m0_data,
    output logic             o_m0_valid,
    input  logic             i_m0_ready,
    output logic             o_m0_last,
    output logic [WIDTH-1:0] o_m1_data,
    output logic             o_m1_valid,
    input  logic             i_m1_ready,
    output logic             o_m1_last,
    output logic             o_busy,
    output logic             o_owner
);

    localparam int OUT_TOTAL = IN_PER_BLOCK * OUT_PER_IN;
    localparam int IN_W      = $clog2(IN_PER_BLOCK + 1);
    localparam int OUT_W     = $clog2(OUT_TOTAL);
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_PER_BLOCK - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_TOTAL - 1);

    sched_state_t     state;
    sched_state_t     state_next;
    logic             owner;
    logic             last_grant;
    logic             busy;
    logic [IN_W-1:0]  in_cnt;
    logic [OUT_W-1:0] out_cnt;
    logic             grant;
    logic             grant_valid;
    logic             owner_in_valid;
    logic             owner_out_ready;
    logic             in_fire;
    logic             out_fire;

    rr_grant2 u_rr_grant2 (
        .valid       ({i_s1_valid, i_s0_valid}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign owner_in_valid  = owner ? i_s1_valid : i_s0_valid;
    assign owner_out_ready = owner ? i_m1_ready : i_m0_ready;
    assign in_fire         = (state == FEED) && owner_in_valid && i_core_in_ready;
    assign out_fire        = (state != IDLE) && i_core_out_valid && owner_out_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = FEED;
            FEED:    if (in_fire && (in_cnt == IN_LAST)) state_next = DRAIN;
            DRAIN:   if (out_fire && (out_cnt == OUT_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Both counters may advance in the same cycle, including on the FEED to DRAIN edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            in_cnt     <= '0;
            out_cnt    <= '0;
        end else if (state == IDLE) begin
            if (grant_valid) begin
                owner   <= grant;
                in_cnt  <= '0;
                out_cnt <= '0;
            end
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + IN_W'(1);
            end
            if (out_fire) begin
                out_cnt <= out_cnt + OUT_W'(1);
            end
            if ((state == DRAIN) && out_fire && (out_cnt == OUT_LAST)) begin
                last_grant <= owner;
                out_cnt    <= '0;
            end
        end
    end

    always_comb begin
        o_core_in_data   = owner ? i_s1_data : i_s0_data;
        o_core_in_valid  = 1'b0;
        o_s0_ready       = 1'b0;
        o_s1_ready       = 1'b0;
        o_core_out_ready = 1'b0;
        o_m0_valid       = 1'b0;
        o_m1_valid       = 1'b0;
        o_m0_last        = 1'b0;
        o_m1_last        = 1'b0;
        if (state == FEED) begin
            o_core_in_valid = owner_in_valid;
            o_s0_ready      = ~owner & i_core_in_ready;
            o_s1_ready      = owner & i_core_in_ready;
        end
        if (state != IDLE) begin
            o_core_out_ready = owner_out_ready;
            o_m0_valid       = ~owner & i_core_out_valid;
            o_m1_valid       = owner & i_core_out_valid;
            o_m0_last        = o_m0_valid && (out_cnt == OUT_LAST);
            o_m1_last        = o_m1_valid && (out_cnt == OUT_LAST);
        end
    end

    assign o_m0_data = i_core_out_data;
    assign o_m1_data = i_core_out_data;
    assign o_busy    = busy;
    assign o_owner   = owner;

endmodule
